inst_fetch_unit: RTL

- Fetch stage directly upstream of the instruction decoder.
- Owns the PC and issues one request at a time to instruction memory over a valid/ready request channel with a valid-only response channel.
- Presents one fetched instruction plus its PC to the decoder over a valid/ready handshake.
- Supports PC redirect from execute and a permanent halt, raised when the decoder retires ebreak (0x00100073).

---
 rtl/fetch_pkg.sv | 15 +
 rtl/inst_fetch_unit_if.sv | 32 +++
 rtl/fetch_pc_reg.sv | 31 +++
 rtl/inst_fetch_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ    = 2'd0,
        FETCH_WAIT   = 2'd1,
        FETCH_OUT    = 2'd2,
        FETCH_HALTED = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-side buses: instruction-memory request/response and decoder handoff.
interface inst_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    // Memory / decoder side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC selection: reset, redirect target, or +4.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_q;

    // PC update: redirect wins over sequential advance; low two bits always cleared on redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= load_pc & ~XLEN'(3);
        end else if (advance) begin
            pc_q <= pc_q + XLEN'(PC_STEP);
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Single-outstanding instruction fetch stage with redirect and permanent halt.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    inst_fetch_unit_if.master      bus,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    input  logic                   halt,
    output logic                   halted,
    output logic [31:0]            fetch_count
);

    fetch_state_e    state_q, state_d;
    logic            drop_q, drop_d;
    logic            hpend_q, hpend_d;
    logic [XLEN-1:0] inst_q, inst_pc_q;
    logic [31:0]     count_q;
    logic [XLEN-1:0] pc;
    logic            pc_load, pc_adv, capture, handoff;
    logic            req_hs, kill;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pc_load),
        .load_pc (redirect_pc),
        .advance (pc_adv),
        .pc      (pc)
    );

    assign req_hs = bus.imem_req_valid && bus.imem_req_ready;
    assign kill   = drop_q || hpend_q || halt || redirect_valid;

    // State register, drop/halt-pending flags, decoder output registers and handoff counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH_REQ;
            drop_q    <= 1'b0;
            hpend_q   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            hpend_q <= hpend_d;
            if (capture) begin
                inst_q    <= bus.imem_resp_data;
                inst_pc_q <= pc;
            end
            if (handoff) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // Next-state and control decode; halt takes priority over redirect
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        hpend_d = hpend_q;
        pc_load = 1'b0;
        pc_adv  = 1'b0;
        capture = 1'b0;
        handoff = 1'b0;
        case (state_q)
            FETCH_REQ: begin
                if (halt) begin
                    // An accepted request must still be drained, so halt then waits in WAIT
                    if (req_hs) begin
                        state_d = FETCH_WAIT;
                        drop_d  = 1'b1;
                        hpend_d = 1'b1;
                    end else begin
                        state_d = FETCH_HALTED;
                    end
                end else if (req_hs) begin
                    state_d = FETCH_WAIT;
                    if (redirect_valid) begin
                        pc_load = 1'b1;
                        drop_d  = 1'b1;
                    end
                end else if (redirect_valid) begin
                    pc_load = 1'b1;
                end
            end
            FETCH_WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (kill) begin
                        drop_d  = 1'b0;
                        hpend_d = 1'b0;
                        if (hpend_q || halt) begin
                            state_d = FETCH_HALTED;
                        end else begin
                            state_d = FETCH_REQ;
                            pc_load = redirect_valid;
                        end
                    end else begin
                        capture = 1'b1;
                        state_d = FETCH_OUT;
                    end
                end else if (halt) begin
                    drop_d  = 1'b1;
                    hpend_d = 1'b1;
                end else if (redirect_valid && !hpend_q) begin
                    pc_load = 1'b1;
                    drop_d  = 1'b1;
                end
            end
            FETCH_OUT: begin
                handoff = bus.inst_ready;
                if (halt) begin
                    state_d = FETCH_HALTED;
                end else if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = FETCH_REQ;
                end else if (bus.inst_ready) begin
                    pc_adv  = 1'b1;
                    state_d = FETCH_REQ;
                end
            end
            FETCH_HALTED: begin
                state_d = FETCH_HALTED;
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase
    end

    assign bus.imem_req_valid = rst_n && (state_q == FETCH_REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = rst_n && (state_q == FETCH_OUT);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign halted             = rst_n && (state_q == FETCH_HALTED);
    assign fetch_count        = count_q;

    // Memory may only answer while a request is outstanding
    a_resp_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_resp_valid |-> (state_q == FETCH_WAIT))
        else $error("imem_resp_valid seen outside WAIT");

endmodule
